// File: rtl/parquimetro_top_if.sv
// Sensor/display bundle for the parking-meter counter.
//
// Signals:
//   a, b        - lane beam sensors, 1 = beam interrupted, synchronous to clk
//   count_sseg  - active-low segment drive {dp, g, f, e, d, c, b, a}; dp always off
//   an          - active-low digit anodes, an[0] = units ... an[3] = thousands
//
// Modports:
//   master - environment side: drives the sensors, observes the display
//   slave  - counter side: reads the sensors, drives the display
interface parquimetro_top_if;
  logic       a;
  logic       b;
  logic [7:0] count_sseg;
  logic [3:0] an;

  modport master (
    output a,
    output b,
    input  count_sseg,
    input  an
  );

  modport slave (
    input  a,
    input  b,
    output count_sseg,
    output an
  );
endinterface

// File: rtl/parquimetro_top.sv
// Decimal parking-meter counter.
//
// A sequence FSM watches the two beam sensors and recognises one complete vehicle
// passage (00 -> 10 -> 11 -> 10 -> 00, each pattern held one or more clocks). Every
// recognised passage adds one to a 4-digit BCD count (0000..9999, wrapping silently).
// The count is shown on a time-multiplexed, active-low 4-digit seven-segment display.
//
// Parameters:
//   REFRESH_BITS - width of the free-running scan counter; its top 2 bits pick the
//                  digit. Must be >= 2. With 2 the scan advances one digit per clock.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low; clears FSM, count and scan counter
//   bus   - sensors in (a, b), display out (count_sseg, an)
module parquimetro_top #(
  parameter int unsigned REFRESH_BITS = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  parquimetro_top_if.slave        bus
);

  typedef enum logic [1:0] {
    StIdle,     // waiting for A to block
    StABlocked, // A blocked, B clear
    StBoth,     // both beams blocked
    StALast     // only A blocked again after both
  } state_e;

  state_e             state_q;
  logic [3:0][3:0]    digits_q;   // digits_q[0] = units
  logic [3:0][3:0]    digits_inc; // digits_q + 1 with decimal carry
  logic [REFRESH_BITS-1:0] scan_q;

  logic [1:0] ab;
  logic [1:0] sel;
  logic [3:0] shown_digit;
  logic [3:0] an_d;
  logic [7:0] sseg_d;

  assign ab = {bus.a, bus.b};

  // BCD increment: a digit rolls 9 -> 0 and passes the carry on; 9999 wraps to 0000.
  always_comb begin
    logic carry;
    carry      = 1'b1;
    digits_inc = digits_q;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (digits_q[i] == 4'd9) begin
          digits_inc[i] = 4'd0;
        end else begin
          digits_inc[i] = digits_q[i] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
  end

  // Passage recogniser and count register. The count moves on the same edge that
  // samples 00 in StALast, so at most one increment per clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      digits_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ab == 2'b10) state_q <= StABlocked;
        end
        StABlocked: begin
          unique case (ab)
            2'b11:   state_q <= StBoth;
            2'b10:   state_q <= StABlocked;
            default: state_q <= StIdle;
          endcase
        end
        StBoth: begin
          unique case (ab)
            2'b10:   state_q <= StALast;
            2'b11:   state_q <= StBoth;
            default: state_q <= StIdle;
          endcase
        end
        StALast: begin
          unique case (ab)
            2'b00: begin
              state_q  <= StIdle;
              digits_q <= digits_inc;
            end
            2'b10:   state_q <= StALast;
            2'b11:   state_q <= StBoth;
            default: state_q <= StIdle; // B cleared first: wrong direction, abort
          endcase
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Free-running display scan counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_q <= '0;
    end else begin
      scan_q <= scan_q + REFRESH_BITS'(1);
    end
  end

  assign sel = scan_q[REFRESH_BITS-1 -: 2];

  // Digit select: decoded purely from registers, so no path from the sensors.
  always_comb begin
    an_d        = 4'b1110;
    shown_digit = digits_q[0];
    unique case (sel)
      2'd0: begin an_d = 4'b1110; shown_digit = digits_q[0]; end
      2'd1: begin an_d = 4'b1101; shown_digit = digits_q[1]; end
      2'd2: begin an_d = 4'b1011; shown_digit = digits_q[2]; end
      2'd3: begin an_d = 4'b0111; shown_digit = digits_q[3]; end
      default: begin an_d = 4'b1110; shown_digit = digits_q[0]; end
    endcase
  end

  // Seven-segment decode, active-low, dp (bit 7) held off.
  always_comb begin
    sseg_d = 8'hFF;
    case (shown_digit)
      4'd0:    sseg_d = 8'hC0;
      4'd1:    sseg_d = 8'hF9;
      4'd2:    sseg_d = 8'hA4;
      4'd3:    sseg_d = 8'hB0;
      4'd4:    sseg_d = 8'h99;
      4'd5:    sseg_d = 8'h92;
      4'd6:    sseg_d = 8'h82;
      4'd7:    sseg_d = 8'hF8;
      4'd8:    sseg_d = 8'h80;
      4'd9:    sseg_d = 8'h90;
      default: sseg_d = 8'hFF; // unreachable: digits never exceed 9
    endcase
  end

  assign bus.an         = an_d;
  assign bus.count_sseg = sseg_d;

endmodule

// File: tb/tb_parquimetro_top.sv
// Bench for parquimetro_top with REFRESH_BITS = 2 (one digit per clock).
// A driver applies sensor patterns and updates a reference model of the meter;
// after every clock it queues the display value the model expects for that cycle.
// A monitor on the falling edge pops and compares against the DUT display.
module tb_parquimetro_top;

  logic clk = 1'b0;
  logic reset;

  parquimetro_top_if bus ();

  parquimetro_top #(
    .REFRESH_BITS(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [7:0] sseg;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: passage progress 0..3 (0 = nothing seen yet), decimal count,
  // clocks since reset. nxt[progress][{a,b}] follows the recognition rules.
  int m_count;
  int m_phase;
  int m_cycles;
  int nxt[4][4] = '{'{0, 0, 1, 0},   // idle:        10 starts
                    '{0, 0, 1, 2},   // A blocked:   11 advances
                    '{0, 0, 3, 2},   // both:        10 advances
                    '{0, 0, 3, 2}};  // A only:      00 completes (counted)
  logic [7:0] seg_lut[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int pow10[4] = '{1, 10, 100, 1000};
  string cur_tag = "reset";

  function automatic void push_exp();
    exp_t e;
    int   s;
    s      = m_cycles % 4;
    e.an   = ~(4'b0001 << s);
    e.sseg = seg_lut[(m_count / pow10[s]) % 10];
    e.tag  = cur_tag;
    sb.push_back(e);
  endfunction

  // Apply {a,b} for one clock, then advance the model past that edge.
  task automatic step(input logic [1:0] ab);
    bus.a = ab[1];
    bus.b = ab[0];
    @(posedge clk);
    #1;
    if (m_phase == 3 && ab == 2'b00) m_count = (m_count + 1) % 10000;
    m_phase = nxt[m_phase][ab];
    m_cycles++;
    push_exp();
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    for (int i = 0; i < n; i++) step(ab);
  endtask

  task automatic passage(input int h);
    hold(2'b10, h);
    hold(2'b11, h);
    hold(2'b10, h);
    hold(2'b00, h);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    bus.a = 1'b0;
    bus.b = 1'b0;
    #1;
    m_count  = 0;
    m_phase  = 0;
    m_cycles = 0;
    push_exp();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (bus.an !== mon_e.an || bus.count_sseg !== mon_e.sseg) begin
        errors++;
        $display("FAIL %s: an=%b sseg=%h, expected an=%b sseg=%h (model count %0d) t=%0t",
                 mon_e.tag, bus.an, bus.count_sseg, mon_e.an, mon_e.sseg, m_count, $time);
      end
    end
  end

  initial begin
    bus.a = 1'b0;
    bus.b = 1'b0;
    reset = 1'b0;
    m_count  = 0;
    m_phase  = 0;
    m_cycles = 0;
    #1;
    push_exp();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    cur_tag = "idle_after_reset";
    hold(2'b00, 4);

    cur_tag = "one_passage";
    passage(1);
    hold(2'b00, 4);
    cur_tag = "second_passage_long_holds";
    hold(2'b10, 2); hold(2'b11, 5); hold(2'b10, 3); hold(2'b00, 4);

    cur_tag = "abort_10_11_00";
    step(2'b10); step(2'b11); step(2'b00); hold(2'b00, 4);
    cur_tag = "abort_reverse";
    step(2'b01); step(2'b11); step(2'b01); step(2'b00); hold(2'b00, 4);
    cur_tag = "bounce_counts_once";
    step(2'b10); step(2'b11); step(2'b10); step(2'b11); step(2'b10); step(2'b00);
    hold(2'b00, 4);
    cur_tag = "abort_01_from_s3";
    step(2'b10); step(2'b11); step(2'b10); step(2'b01); step(2'b00); hold(2'b00, 4);

    cur_tag = "carry_to_tens";
    while (m_count < 9) passage(1);
    hold(2'b00, 4);
    passage(1);
    hold(2'b00, 4);

    cur_tag = "reset_mid_passage";
    step(2'b10); step(2'b11);
    do_reset();
    step(2'b10); step(2'b00); hold(2'b00, 4);

    cur_tag = "scan_1234";
    while (m_count < 1234) passage(1);
    hold(2'b00, 8);

    cur_tag = "random";
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(1, 0) == 1) begin
        hold(2'b10, $urandom_range(3, 1));
        hold(2'b11, $urandom_range(3, 1));
        if ($urandom_range(3, 0) == 0) begin
          hold(2'b10, $urandom_range(2, 1));
          hold(2'b11, $urandom_range(2, 1));
        end
        hold(2'b10, $urandom_range(3, 1));
        hold(2'b00, $urandom_range(3, 1));
      end else begin
        for (int k = 0; k < $urandom_range(6, 1); k++) begin
          hold(2'($urandom_range(3, 0)), $urandom_range(3, 1));
        end
      end
    end
    hold(2'b00, 4);

    cur_tag = "wrap_9999";
    do_reset();
    while (m_count < 9999) passage(1);
    hold(2'b00, 4);
    cur_tag = "wrap_to_0000";
    passage(1);
    hold(2'b00, 4);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parquimetro_top.md
# parquimetro_top

Top level of the decimal parking-meter counter. Two beam sensors, `a` and `b`, watch the entry lane. A sequence FSM recognises one complete vehicle passage and increments a 4-digit BCD count. The count is shown on a 4-digit, time-multiplexed, active-low seven-segment display.

## Interface

- `REFRESH_BITS`, default 18: width of the free-running scan counter. The top 2 bits select the digit. Set to 2 in simulation so the scan advances one digit per clock.
- `clk`, input, 1 bit: single system clock. Everything updates on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset. It clears all state immediately.
- `a`, input, 1 bit: sensor A, 1 = beam interrupted. It is synchronous to `clk`; debounce and synchronisation are done upstream.
- `b`, input, 1 bit: sensor B, same convention as `a`.
- `count_sseg`, output, 8 bits: segment drive, active-low.
  - Bit 7 is dp and is always 1 (off).
  - Bits 6..0 are segments g,f,e,d,c,b,a.
- `an`, output, 4 bits: digit anodes, active-low, exactly one low at a time.
  - `an[0]` = units, `an[3]` = thousands.

## Operation

- The FSM samples `{a,b}` on every clock. States and transitions:
  - IDLE: on 10 go to S1; otherwise stay.
  - S1 (A blocked): 11 → S2; 10 → stay; 00 or 01 → IDLE (abort).
  - S2 (both blocked): 10 → S3; 11 → stay; 00 or 01 → IDLE (abort).
  - S3 (A only, after both): 00 → IDLE and increment the count; 10 → stay; 11 → S2; 01 → IDLE (abort).
- A valid passage is therefore 00 → 10 → 11 → 10 → 00. Each pattern may last 1 or more clocks.
- Patterns beginning with 01 are never counted.
- Counter: four BCD digits, range 0000–9999.
  - Increment is +1 with decimal carry between digits.
  - 9999 + 1 wraps to 0000 with no flag.
  - At most one increment per clock.
- Display:
  - A free-running `REFRESH_BITS`-bit scan counter drives the display. Its top 2 bits, `sel`, choose the digit: 0 = units, 1 = tens, 2 = hundreds, 3 = thousands.
  - `an` = 1110, 1101, 1011, 0111 for `sel` = 0, 1, 2, 3.
  - `count_sseg` shows the selected digit. Leading zeros are displayed.
- Segment codes, digits 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex).
- Reset values:
  - FSM = IDLE, count = 0000, scan counter = 0.
  - `an` = 1110 and `count_sseg` = 8'hC0.

## Timing

- The count register updates on the same rising edge that samples 00 while the FSM is in S3. The new count is visible immediately after that edge, so latency is 0 cycles from the sampling edge.
- Outputs are registered or purely decoded from registers. They have no combinational path from `a` or `b`.
- `an` and `count_sseg` change together, when the digit selection changes. The selection changes every 2^(REFRESH_BITS−2) clocks.
- The displayed digit reflects the count as it stands in that same cycle.
- Asserting `reset` low mid-passage returns the FSM to IDLE and clears the count asynchronously. A partial passage in progress is lost.
- After reset releases, a passage is recognised only if it starts again from 10.

## Test plan

- Reset: hold `reset`=0, then release with `{a,b}`=00 → `an`=1110, `count_sseg`=C0, count=0000.
- One passage: apply 10, 11, 10, 00, each for one clock → count=0001 right after the edge sampling 00; units digit shows F9.
- Second passage, identical → count=0002 (units shows A4). Patterns held for several clocks (e.g. 11 for 5 clocks) still count once.
- Aborts:
  - 10, 11, 00 → count unchanged, FSM in IDLE.
  - 01, 11, 01, 00 → unchanged.
  - 10, 11, 10, 11, 10, 00 → +1 exactly.
- Carry and wrap:
  - 9 passages → 0009; the 10th → 0010 (tens shows F9, units C0).
  - Preloaded to 9999 via 9999 passages, one more → 0000.
- Scan with `REFRESH_BITS`=2, count=1234:
  - `an` steps 1110, 1101, 1011, 0111, then repeats.
  - `count_sseg` = 99, B0, A4, F9 in step.
  - `reset` pulsed low mid-passage in S2 → count 0000 immediately, no increment on the following 10, 00.
